// File: rtl/mines_board_renderer.sv
// Minesweeper board renderer: walks the 4x4 tile grid and streams one RGB pixel per cycle
// into the frame buffer, using a snapshot of the game state taken when start is accepted.

module mines_nbr_count #(
    parameter int IDX = 0
) (
    input  logic [15:0] map_i,
    output logic [3:0]  cnt_o
);
    always_comb begin
        int r, c;
        cnt_o = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                r = IDX / 4 + dr;
                c = IDX % 4 + dc;
                if (!(dr == 0 && dc == 0) && r >= 0 && r < 4 && c >= 0 && c < 4)
                    cnt_o = cnt_o + {3'b000, map_i[4'(r * 4 + c)]};
            end
        end
    end
endmodule

module mines_board_renderer #(
    parameter int FB_W   = 160,
    parameter int TILE_W = 40,
    parameter int TILE_H = 30
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [15:0] mine_map_i,
    input  logic [15:0] revealed_i,
    input  logic [3:0]  cursor_i,
    input  logic        game_over_i,
    input  logic        fb_wait_i,
    output logic [14:0] fb_addr_o,
    output logic [23:0] fb_data_o,
    output logic        fb_we_o,
    output logic        busy_o,
    output logic        done_o
);
    localparam logic [23:0] C_CURSOR = 24'hFFFF00;
    localparam logic [23:0] C_BORDER = 24'h404040;
    localparam logic [23:0] C_MINE   = 24'hC00000;
    localparam logic [23:0] C_BLACK  = 24'h000000;
    localparam logic [23:0] C_HIDDEN = 24'h808080;
    localparam logic [23:0] C_WHITE  = 24'hFFFFFF;
    localparam logic [23:0] C_ONE    = 24'h00C000;
    localparam logic [23:0] C_TWO    = 24'h0000FF;
    localparam logic [23:0] C_MANY   = 24'hFF0000;

    typedef enum logic [1:0] {S_IDLE, S_LATCH, S_DRAW, S_DONE} state_e;

    state_e       state_q;
    logic [15:0]  mine_q, rev_q;
    logic [3:0]   cur_q;
    logic         go_q;
    logic [15:0][3:0] cnt_q, cnt_w;
    logic [3:0]   tile_q;
    logic [5:0]   px_q;
    logic [4:0]   py_q;
    logic [14:0]  fb_addr_q;
    logic [23:0]  fb_data_q;
    logic         fb_we_q, busy_q, done_q;

    for (genvar t = 0; t < 16; t++) begin : g_cnt
        mines_nbr_count #(.IDX(t)) u_cnt (.map_i(mine_q), .cnt_o(cnt_w[t]));
    end

    // Successor of the pixel currently on the bus, in tile/py/px scan order.
    logic [3:0] tile_d;
    logic [5:0] px_d;
    logic [4:0] py_d;
    logic       last_w;
    always_comb begin
        tile_d = tile_q;
        px_d   = px_q + 6'd1;
        py_d   = py_q;
        last_w = (tile_q == 4'd15) && (px_q == 6'(TILE_W - 1)) && (py_q == 5'(TILE_H - 1));
        if (px_q == 6'(TILE_W - 1)) begin
            px_d = '0;
            if (py_q == 5'(TILE_H - 1)) begin
                py_d   = '0;
                tile_d = tile_q + 4'd1;
            end else begin
                py_d = py_q + 5'd1;
            end
        end
    end

    // The first write of a frame presents the cleared counters; later ones present the successor.
    logic [3:0]  tile_s;
    logic [5:0]  px_s;
    logic [4:0]  py_s;
    logic [14:0] row_w, addr_w;
    logic [23:0] data_w;
    logic        border_w, glyph_w, shown_w;
    always_comb begin
        tile_s   = fb_we_q ? tile_d : tile_q;
        px_s     = fb_we_q ? px_d   : px_q;
        py_s     = fb_we_q ? py_d   : py_q;
        row_w    = 15'(tile_s[3:2]) * 15'(TILE_H) + 15'(py_s);
        addr_w   = row_w * 15'(FB_W) + 15'(tile_s[1:0]) * 15'(TILE_W) + 15'(px_s);
        border_w = (px_s == 6'd0) || (py_s == 5'd0);
        glyph_w  = (px_s >= 6'd15) && (px_s <= 6'd24) && (py_s >= 5'd10) && (py_s <= 5'd19);
        shown_w  = mine_q[tile_s] && (rev_q[tile_s] || go_q);
        data_w   = C_WHITE;
        if (border_w)
            data_w = (tile_s == cur_q) ? C_CURSOR : C_BORDER;
        else if (shown_w)
            data_w = glyph_w ? C_BLACK : C_MINE;
        else if (!rev_q[tile_s])
            data_w = C_HIDDEN;
        else if (glyph_w) begin
            case (cnt_q[tile_s])
                4'd0:    data_w = C_WHITE;
                4'd1:    data_w = C_ONE;
                4'd2:    data_w = C_TWO;
                default: data_w = C_MANY;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            mine_q    <= '0;
            rev_q     <= '0;
            cur_q     <= '0;
            go_q      <= 1'b0;
            cnt_q     <= '0;
            tile_q    <= '0;
            px_q      <= '0;
            py_q      <= '0;
            fb_addr_q <= '0;
            fb_data_q <= '0;
            fb_we_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        mine_q  <= mine_map_i;
                        rev_q   <= revealed_i;
                        cur_q   <= cursor_i;
                        go_q    <= game_over_i;
                        state_q <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    cnt_q   <= cnt_w;
                    tile_q  <= '0;
                    px_q    <= '0;
                    py_q    <= '0;
                    busy_q  <= 1'b1;
                    state_q <= S_DRAW;
                end
                S_DRAW: begin
                    if (!fb_we_q) begin
                        fb_we_q   <= 1'b1;
                        fb_addr_q <= addr_w;
                        fb_data_q <= data_w;
                    end else if (!fb_wait_i) begin
                        if (last_w) begin
                            fb_we_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            tile_q    <= tile_d;
                            px_q      <= px_d;
                            py_q      <= py_d;
                            fb_addr_q <= addr_w;
                            fb_data_q <= data_w;
                        end
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign fb_addr_o = fb_addr_q;
    assign fb_data_o = fb_data_q;
    assign fb_we_o   = fb_we_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
endmodule

// File: tb/tb_mines_board_renderer.sv
// Directed bench: renders whole frames into a shadow frame buffer, then checks
// table-driven pixels plus timing, back-pressure, ignored-start and mid-frame reset.

module tb_mines_board_renderer;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, game_over = 1'b0, fb_wait = 1'b0;
    logic [15:0] mine_map = '0, revealed = '0;
    logic [3:0]  cursor = '0;
    logic [14:0] fb_addr;
    logic [23:0] fb_data;
    logic        fb_we, busy, done;

    mines_board_renderer dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mine_map_i(mine_map),
        .revealed_i(revealed), .cursor_i(cursor), .game_over_i(game_over),
        .fb_wait_i(fb_wait), .fb_addr_o(fb_addr), .fb_data_o(fb_data),
        .fb_we_o(fb_we), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0, wr_cnt = 0, done_cnt = 0, done_cyc = 0;
    logic [23:0] mem [0:19199];

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Inputs only change at posedge+1, so a write seen here is accepted at the next edge.
    always @(negedge clk) begin
        if (fb_we && !fb_wait) begin
            mem[fb_addr] <= fb_data;
            wr_cnt       <= wr_cnt + 1;
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc_cnt;
        end
    end

    typedef struct {
        int          frame;
        int          addr;
        logic [23:0] exp;
    } vec_t;
    vec_t vecs[$];

    int n_cmp = 0, n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic add(input int f, input int a, input logic [23:0] e);
        vec_t v;
        v.frame = f; v.addr = a; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(output int t0);
        start = 1'b1;
        tick();
        t0 = cyc_cnt;
        start = 1'b0;
    endtask

    task automatic wait_writes(input int base, input int n);
        int g = 0;
        while (wr_cnt - base < n && g < 30000) begin tick(); g++; end
        if (g >= 30000) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_writes: got %0d want %0d", wr_cnt - base, n);
        end
    endtask

    task automatic wait_done(input int d0);
        int g = 0;
        while (done_cnt == d0 && g < 30000) begin tick(); g++; end
        if (g >= 30000) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_done: got timeout want done");
        end
    endtask

    task automatic check_frame(input int f);
        foreach (vecs[i])
            if (vecs[i].frame == f)
                check($sformatf("pix_f%0d_a%0d", f, vecs[i].addr), mem[vecs[i].addr], vecs[i].exp);
    endtask

    task automatic finish_frame(input string nm, input int t0, input int w0, input int d0,
                                input int lat);
        wait_done(d0);
        check({nm, "_done_lat"}, done_cyc - t0, lat);
        check({nm, "_busy_at_done"}, busy, 0);
        check({nm, "_we_at_done"}, fb_we, 0);
        tick();
        check({nm, "_done_pulse"}, done, 0);
        tick();
        check({nm, "_writes"}, wr_cnt - w0, 19200);
        check({nm, "_done_count"}, done_cnt - d0, 1);
    endtask

    initial begin
        int t0, w0, d0;
        logic [14:0] a_h;
        logic [23:0] d_h;

        add(1, 0, 24'hFFFF00);     add(1, 1, 24'hFFFF00);     add(1, 161, 24'h808080);
        add(1, 40, 24'h404040);    add(1, 4800, 24'h404040);  add(1, 805, 24'h808080);
        add(1, 19199, 24'h808080);
        add(2, 2460, 24'h00C000);  add(2, 845, 24'hFFFFFF);   add(2, 805, 24'h808080);
        add(2, 2420, 24'h808080);  add(2, 1655, 24'h00C000);  add(2, 1654, 24'hFFFFFF);
        add(2, 3104, 24'h00C000);  add(2, 3105, 24'hFFFFFF);  add(2, 3264, 24'hFFFFFF);
        add(2, 2490, 24'h808080);  add(2, 840, 24'h404040);   add(2, 0, 24'hFFFF00);
        add(3, 2420, 24'hFF0000);  add(3, 7260, 24'h000000);  add(3, 5645, 24'hC00000);
        add(3, 7254, 24'hC00000);  add(3, 5605, 24'hC00000);  add(3, 2460, 24'h000000);
        add(3, 2490, 24'h808080);  add(3, 4840, 24'hFFFF00);  add(3, 0, 24'h404040);
        add(3, 805, 24'hFFFFFF);   add(3, 12020, 24'h0000FF); add(3, 16940, 24'hFFFFFF);

        // Reset state
        tick(); tick();
        check("rst_addr", fb_addr, 0);
        check("rst_data", fb_data, 0);
        check("rst_we", fb_we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        tick();

        // Frame 1: empty board, latency and totals
        w0 = wr_cnt; d0 = done_cnt;
        start_frame(t0);
        check("f1_busy_n0", busy, 0);
        tick();
        check("f1_busy_n1", busy, 1);
        check("f1_we_n1", fb_we, 0);
        tick();
        check("f1_we_n2", fb_we, 1);
        check("f1_addr_n2", fb_addr, 0);
        check("f1_data_n2", fb_data, 24'hFFFF00);
        finish_frame("f1", t0, w0, d0, 19202);
        check_frame(1);

        // Frame 2: back-pressure, ignored start, late input changes
        mine_map = 16'h0001; revealed = 16'h0002; cursor = 4'd0; game_over = 1'b0;
        w0 = wr_cnt; d0 = done_cnt;
        start_frame(t0);
        wait_writes(w0, 100);
        fb_wait = 1'b1;
        a_h = fb_addr; d_h = fb_data;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("stall_addr_%0d", i), fb_addr, a_h);
            check($sformatf("stall_data_%0d", i), fb_data, d_h);
            check($sformatf("stall_we_%0d", i), fb_we, 1);
        end
        fb_wait = 1'b0;
        wait_writes(w0, 500);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_busy", busy, 1);
        wait_writes(w0, 600);
        revealed = 16'hFFFF;
        mine_map = 16'hFFFF;
        finish_frame("f2", t0, w0, d0, 19207);
        check_frame(2);

        // Frame 3: counts, shown mines under game_over, cursor away from tile 0
        mine_map = 16'h0032; revealed = 16'h8101; cursor = 4'd5; game_over = 1'b1;
        w0 = wr_cnt; d0 = done_cnt;
        start_frame(t0);
        finish_frame("f3", t0, w0, d0, 19202);
        check_frame(3);

        // Frame 4: reset mid-frame, then a fresh redraw
        mine_map = '0; revealed = '0; cursor = '0; game_over = 1'b0;
        w0 = wr_cnt; d0 = done_cnt;
        start_frame(t0);
        wait_writes(w0, 1000);
        rst_n = 1'b0;
        #1;
        check("mid_rst_we", fb_we, 0);
        check("mid_rst_busy", busy, 0);
        tick(); tick();
        check("mid_rst_no_done", done_cnt - d0, 0);
        rst_n = 1'b1;
        tick();
        start_frame(t0);
        tick();
        check("redraw_busy", busy, 1);
        tick();
        check("redraw_we", fb_we, 1);
        check("redraw_addr", fb_addr, 0);
        check("redraw_data", fb_data, 24'hFFFF00);
        rst_n = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
